// File: rtl/blink_pkg.sv
// Shared definitions for the LED blinker control path.
// Provides the rate-select encoding seen by the blinker, the default
// debounce window and the mode-advance helper used by the selector.
package blink_pkg;

    // Rate-select encoding presented on {select_s1, select_s0}
    typedef enum logic [1:0] {
        MODE_10HZ = 2'b00,
        MODE_5HZ  = 2'b01,
        MODE_2HZ  = 2'b10,
        MODE_1HZ  = 2'b11
    } mode_e;

    // 10 ms at a 50 MHz system clock
    localparam int DEFAULT_DEBOUNCE_CNT = 500_000;

    // Advance to the next blink rate, wrapping from the slowest back to the fastest
    function automatic mode_e next_mode(input mode_e cur);
        case (cur)
            MODE_10HZ: next_mode = MODE_5HZ;
            MODE_5HZ:  next_mode = MODE_2HZ;
            MODE_2HZ:  next_mode = MODE_1HZ;
            MODE_1HZ:  next_mode = MODE_10HZ;
            default:   next_mode = MODE_10HZ;
        endcase
    endfunction

endpackage

// File: rtl/blink_mode_selector_if.sv
// Button-in / blinker-out bundle of the blink mode selector.
//   i_btn_mode, i_btn_en : raw active-high push-buttons (asynchronous)
//   o_select_s1/s0       : rate select to the blinker
//   o_enable             : LED enable to the blinker
//   o_mode_pulse         : one-cycle strobe when a new mode appears
// master = the selector, slave = the button/blinker side.
interface blink_mode_selector_if;
    logic i_btn_mode;
    logic i_btn_en;
    logic o_select_s1;
    logic o_select_s0;
    logic o_enable;
    logic o_mode_pulse;

    modport master (
        input  i_btn_mode,
        input  i_btn_en,
        output o_select_s1,
        output o_select_s0,
        output o_enable,
        output o_mode_pulse
    );

    modport slave (
        output i_btn_mode,
        output i_btn_en,
        input  o_select_s1,
        input  o_select_s0,
        input  o_enable,
        input  o_mode_pulse
    );
endinterface

// File: rtl/btn_debounce.sv
// One push-button front end: synchroniser, debounce filter and press detect.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_btn          : raw button level (asynchronous to i_clk)
//   o_level        : debounced stable level
//   o_press        : registered one-cycle strobe on an accepted 0->1 of o_level
// The level changes only after the synchronised input has differed from it for
// DEBOUNCE_CNT consecutive cycles; any return to the stable level restarts the count.
module btn_debounce #(
    parameter int DEBOUNCE_CNT = 500_000,
    parameter int CNT_WIDTH    = 19,
    parameter int SYNC_STAGES  = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic                   level_r;
    logic                   level_prev_r;
    logic                   press_r;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Plain flop chain, nothing between stages
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], i_btn};
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CNT consecutive differing samples
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else if (sync_s == level_r) begin
            cnt_r   <= '0;
            level_r <= level_r;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            level_r <= sync_s;
        end else begin
            cnt_r   <= cnt_r + CNT_WIDTH'(1);
            level_r <= level_r;
        end
    end

    // Press detect: rising edge of the stable level, registered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level_prev_r <= 1'b0;
            press_r      <= 1'b0;
        end else begin
            level_prev_r <= level_r;
            press_r      <= level_r & ~level_prev_r;
        end
    end

    assign o_level = level_r;
    assign o_press = press_r;

endmodule

// File: rtl/blink_mode_selector.sv
// Upstream control stage for the LED blinker.
//   i_clk   : 50 MHz system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : blink_mode_selector_if.master - raw buttons in, select/enable/pulse out
// BTN_MODE steps the rate 10 -> 5 -> 2 -> 1 Hz -> 10 Hz; BTN_EN toggles LED drive.
// Every output comes straight from a flop, so the blinker never sees a
// combinational path from the buttons.
module blink_mode_selector
    import blink_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEFAULT_DEBOUNCE_CNT,
    parameter int CNT_WIDTH    = 19,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    blink_mode_selector_if.master bus
);

    logic  mode_press_s;
    logic  en_press_s;
    logic  mode_level_unused_s;
    logic  en_level_unused_s;
    mode_e mode_r;
    logic  enable_r;
    logic  mode_pulse_r;

    btn_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .CNT_WIDTH    (CNT_WIDTH),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_btn_mode (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (bus.i_btn_mode),
        .o_level (mode_level_unused_s),
        .o_press (mode_press_s)
    );

    btn_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .CNT_WIDTH    (CNT_WIDTH),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_btn_en (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (bus.i_btn_en),
        .o_level (en_level_unused_s),
        .o_press (en_press_s)
    );

    // Mode counter, enable toggle and mode strobe; both presses act in the same cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_r       <= MODE_10HZ;
            enable_r     <= 1'b0;
            mode_pulse_r <= 1'b0;
        end else begin
            if (mode_press_s) begin
                mode_r <= next_mode(mode_r);
            end else begin
                mode_r <= mode_r;
            end
            if (en_press_s) begin
                enable_r <= ~enable_r;
            end else begin
                enable_r <= enable_r;
            end
            // Pulse is registered alongside mode_r so it marks the first cycle of the new value
            mode_pulse_r <= mode_press_s;
        end
    end

    assign bus.o_select_s1  = mode_r[1];
    assign bus.o_select_s0  = mode_r[0];
    assign bus.o_enable     = enable_r;
    assign bus.o_mode_pulse = mode_pulse_r;

endmodule
